// File: rtl/plugin_pixel_stream_gray.sv
// Streaming RGB-to-grayscale converter with a 2-stage valid/ready pipeline
// and a start/busy/done job handshake over a programmed pixel count.
module plugin_pixel_stream_gray #(
    parameter int CH_W    = 8,
    parameter int COUNT_W = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [1:0]          mode,
    input  logic [CH_W-1:0]     threshold,
    input  logic [COUNT_W-1:0]  pixel_count,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [4*CH_W-1:0]   in_pixel,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [4*CH_W-1:0]   out_pixel,
    output logic                busy,
    output logic                done
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam int SUM_W  = CH_W + 2;
    localparam int LUMA_W = CH_W + 8;

    logic [1:0]         state;
    logic [1:0]         mode_q;
    logic [CH_W-1:0]    thr_q;
    logic [COUNT_W-1:0] cnt_q;
    logic [COUNT_W-1:0] in_cnt;
    logic [COUNT_W-1:0] out_cnt;

    logic               vld_p1;
    logic               vld_p2;
    logic [CH_W-1:0]    y_avg_p1;
    logic [CH_W-1:0]    y_g2_p1;
    logic [CH_W-1:0]    y_luma_p1;
    logic [4*CH_W-1:0]  pix_p2;

    logic [CH_W-1:0]    r;
    logic [CH_W-1:0]    g;
    logic [CH_W-1:0]    b;
    logic [SUM_W-1:0]   sum_avg;
    logic [SUM_W-1:0]   sum_g2;
    logic [LUMA_W-1:0]  luma;
    logic [CH_W-1:0]    y_sel;
    logic               unused_bits;

    logic ld_p1;
    logic ld_p2;
    logic start_ok;
    logic in_fire;
    logic out_fire;

    // Picks the final luminance from the precomputed stage-1 candidates.
    function automatic logic [CH_W-1:0] select_y(
        input logic [1:0]      m,
        input logic [CH_W-1:0] thr,
        input logic [CH_W-1:0] ya,
        input logic [CH_W-1:0] yg,
        input logic [CH_W-1:0] yl
    );
        case (m)
            2'd0:    return ya;
            2'd1:    return yg;
            2'd2:    return yl;
            default: return (yl >= thr) ? {CH_W{1'b1}} : {CH_W{1'b0}};
        endcase
    endfunction

    assign r = in_pixel[4*CH_W-1 -: CH_W];
    assign g = in_pixel[3*CH_W-1 -: CH_W];
    assign b = in_pixel[2*CH_W-1 -: CH_W];

    assign sum_avg = SUM_W'(r) + SUM_W'(g) + SUM_W'(b);
    assign sum_g2  = SUM_W'(r) + (SUM_W'(g) << 1) + SUM_W'(b);
    assign luma    = LUMA_W'(77) * LUMA_W'(r) + LUMA_W'(150) * LUMA_W'(g)
                   + LUMA_W'(29) * LUMA_W'(b);

    assign unused_bits = ^{in_pixel[CH_W-1:0], sum_avg[1:0], sum_g2[1:0], luma[7:0]};

    assign ld_p2    = !vld_p2 || out_ready;
    assign ld_p1    = !vld_p1 || ld_p2;
    assign start_ok = (state == IDLE) && start;
    assign in_ready = (state == RUN) && (in_cnt < cnt_q) && ld_p1;
    assign in_fire  = in_valid && in_ready;
    assign out_fire = vld_p2 && out_ready;

    assign out_valid = vld_p2;
    assign out_pixel = pix_p2;
    assign busy      = (state == RUN);
    assign done      = (state == DONE);
    assign y_sel     = select_y(mode_q, thr_q, y_avg_p1, y_g2_p1, y_luma_p1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            in_cnt  <= '0;
            out_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        in_cnt  <= '0;
                        out_cnt <= '0;
                        state   <= (pixel_count != '0) ? RUN : DONE;
                    end
                end
                RUN: begin
                    if (in_fire) in_cnt <= in_cnt + COUNT_W'(1);
                    if (out_fire) begin
                        out_cnt <= out_cnt + COUNT_W'(1);
                        if (out_cnt == cnt_q - COUNT_W'(1)) state <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Job configuration is captured once so port changes mid-job have no effect.
    always_ff @(posedge clk) begin
        if (start_ok) begin
            mode_q <= mode;
            thr_q  <= threshold;
            cnt_q  <= pixel_count;
        end
    end

    // Stage 1: channel sums already shifted down to channel width.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p1 <= 1'b0;
        end else if (ld_p1) begin
            vld_p1 <= in_fire;
        end
    end

    always_ff @(posedge clk) begin
        if (ld_p1 && in_fire) begin
            y_avg_p1  <= sum_avg[SUM_W-1:2];
            y_g2_p1   <= sum_g2[SUM_W-1:2];
            y_luma_p1 <= luma[LUMA_W-1:8];
        end
    end

    // Stage 2: final Y replicated into the output word.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p2 <= 1'b0;
            pix_p2 <= '0;
        end else if (ld_p2) begin
            vld_p2 <= vld_p1;
            if (vld_p1) pix_p2 <= {y_sel, y_sel, y_sel, {CH_W{1'b0}}};
        end
    end

endmodule
